spi_slave: RTL and testbench
============================

Name: spi_slave

Overview:
- SPI responder, 8-bit frames, mode 0 (CPOL=0, CPHA=0), MSB first, counterpart to the team's SPI master.
- Runs on the system clock. Oversamples cs/sclk/mosi through synchronizers and detects sclk edges in the clk domain.
- Delivers each received byte with a one-cycle done pulse, and shifts out a byte presented on data_in.
- Sits between the SPI pins and the AES core's byte-level datapath.

Parameters:
SYNC_STAGES, 2, flip-flop stages on cs, sclk and mosi before edge detection (legal ≥2)

Ports:
clk       input   1  system clock, all logic on rising edge
reset     input   1  asynchronous, active-low reset (reset=0 clears all state immediately)
cs        input   1  chip select from master, active low
sclk      input   1  serial clock from master, idles low
mosi      input   1  serial data from master
miso      output  1  serial data to master
data_in   input   8  byte to transmit; sampled at frame start and at each byte boundary
data_out  output  8  last complete received byte
done      output  1  one-cycle pulse: data_out updated this cycle
abort     output  1  one-cycle pulse: cs deasserted mid-byte
buzy      output  1  high while synchronized cs is low

Behaviour:
- Reset values: miso=0, data_out=8'h00, done=0, abort=0, buzy=0. Internal state: state=IDLE, bit counter=0, shift registers=0, synchronizer flops=1 for cs and 0 for sclk and mosi.
- Synchronization: cs_s, sclk_s and mosi_s are the last synchronizer stages. Edges are found by comparing against a delay register.
  - sclk_rise: sclk_s=1, previous=0.
  - sclk_fall: sclk_s=0, previous=1.
  - cs_fall and cs_rise are defined likewise on cs_s.
- Input timing requirement: sclk high and low phases are each ≥3 clk cycles. mosi is stable across a synchronized rising edge.
- FSM states: IDLE and ACTIVE.
  - IDLE, on cs_fall: go to ACTIVE, load tx_reg=data_in, drive miso=data_in[7], tx_reg<<=1, counter=0.
  - IDLE: sclk edges are ignored and miso is held at 0.
  - ACTIVE, on sclk_rise: rx_reg={rx_reg[6:0],mosi_s}, counter++.
    - When counter was 7, counter wraps to 0 and the byte completes:
      - data_out={rx_reg[6:0],mosi_s}
      - done=1 for exactly one cycle
      - tx_reg=data_in (reload for the next byte)
  - ACTIVE, on sclk_fall: miso=tx_reg[7], tx_reg<<=1.
  - Result on the pins: bit n of the outgoing byte is valid before the nth rising edge. The falling edge after the 8th rising edge presents the next byte's MSB.
  - ACTIVE, on cs_rise: go to IDLE, miso=0.
    - counter≠0: pulse abort=1 for one cycle, discard the partial rx_reg, leave data_out unchanged.
    - counter=0: clean frame end, no abort.
- Multi-byte frames: cs stays low and bytes chain back to back. done fires once per byte; the counter wraps 7→0.
- Simultaneous events:
  - cs_rise in the same cycle as sclk_rise: cs_rise wins and the sclk edge is ignored. No done, abort only if counter≠0.
  - cs_fall and sclk_rise together: cannot occur under the timing requirement, so it is undefined.
- Reset asserted mid-frame: all state clears asynchronously and no done or abort is produced. After reset release, a new cs_fall is needed to start, even if cs is already low.
- buzy = (state==ACTIVE).
- done and abort are never high together.

Test Plan:
1. Master sends 8'hA5, data_in=8'h3C, sclk at clk/8 → data_out=8'hA5 with a single done pulse. Master captures 8'h3C on miso (MSB valid before the first rising edge).
2. One cs-low frame carries 8'h01 then 8'hFE; data_in changes 8'h11→8'h22 after the first done → two done pulses, data_out 8'h01 then 8'hFE. miso carries 8'h11 then 8'h22.
3. cs rises after 5 sclk rising edges with data_out previously 8'h5A → abort pulses once, no done, data_out stays 8'h5A. The next full frame of 8'hC3 yields data_out=8'hC3.
4. reset driven low mid-byte (after 3 bits) → outputs clear immediately: data_out=0, miso=0, buzy=0. After release plus a fresh cs_fall, 8'h7E is received correctly.
5. sclk toggles with cs high → no done, miso=0, buzy=0, data_out unchanged.
6. Randomized 16 back-to-back bytes at minimum sclk phase (3 clk) → all bytes match in both directions, and done is never asserted in the same cycle as abort.

Source files
------------

// File: rtl/spi_slave_if.sv
// SPI pin and byte-level signals shared between the slave and its user.
interface spi_slave_if;
  logic       cs;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       done;
  logic       abort;
  logic       buzy;

  modport slave (
    input  cs, sclk, mosi, data_in,
    output miso, data_out, done, abort, buzy
  );

  modport master (
    output cs, sclk, mosi, data_in,
    input  miso, data_out, done, abort, buzy
  );
endinterface

// File: rtl/spi_slave.sv
// SPI mode-0 responder, 8-bit MSB-first frames, oversampled on clk.
module spi_slave #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  spi_slave_if.slave  bus
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, mosi_sync, fill;
  logic       cs_s, sclk_s, mosi_s;
  logic       cs_d, sclk_d, armed;
  logic       cs_fall, cs_rise, sclk_rise, sclk_fall;

  state_t     state, state_n;
  logic [2:0] cnt, cnt_n;
  logic [7:0] rx_reg, rx_n;
  logic [7:0] tx_reg, tx_n;
  logic [7:0] dout, dout_n;
  logic       miso_r, miso_n;
  logic       done_r, done_n;
  logic       abort_r, abort_n;

  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // fill marks when every synchronizer stage holds a real pin sample; cs must
  // be seen high after reset before a falling edge may start a frame, so a cs
  // already low at reset release does not fake a cs_fall from the reset value.
  assign cs_fall   = armed & cs_d & ~cs_s;
  assign cs_rise   = ~cs_d & cs_s;
  assign sclk_rise = ~sclk_d & sclk_s;
  assign sclk_fall = sclk_d & ~sclk_s;

  // Input synchronizers and edge-detect delay registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cs_sync   <= '1;
      sclk_sync <= '0;
      mosi_sync <= '0;
      fill      <= '0;
      cs_d      <= 1'b1;
      sclk_d    <= 1'b0;
      armed     <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.cs};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      fill      <= {fill[SYNC_STAGES-2:0], 1'b1};
      cs_d      <= cs_s;
      sclk_d    <= sclk_s;
      armed     <= armed | (fill[SYNC_STAGES-1] & cs_s);
    end
  end

  // FSM and datapath state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      rx_reg  <= '0;
      tx_reg  <= '0;
      dout    <= '0;
      miso_r  <= 1'b0;
      done_r  <= 1'b0;
      abort_r <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      rx_reg  <= rx_n;
      tx_reg  <= tx_n;
      dout    <= dout_n;
      miso_r  <= miso_n;
      done_r  <= done_n;
      abort_r <= abort_n;
    end
  end

  // Next-state, shift and pulse logic; cs_rise takes priority over sclk edges
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rx_n    = rx_reg;
    tx_n    = tx_reg;
    dout_n  = dout;
    miso_n  = miso_r;
    done_n  = 1'b0;
    abort_n = 1'b0;
    case (state)
      IDLE: begin
        miso_n = 1'b0;
        if (cs_fall) begin
          state_n = ACTIVE;
          tx_n    = {bus.data_in[6:0], 1'b0};
          miso_n  = bus.data_in[7];
          cnt_n   = '0;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_n = IDLE;
          miso_n  = 1'b0;
          abort_n = (cnt != 3'd0);
          cnt_n   = '0;
          rx_n    = '0;
        end else if (sclk_rise) begin
          rx_n  = {rx_reg[6:0], mosi_s};
          cnt_n = cnt + 3'd1;
          if (cnt == 3'd7) begin
            dout_n = {rx_reg[6:0], mosi_s};
            done_n = 1'b1;
            tx_n   = bus.data_in;
          end
        end else if (sclk_fall) begin
          miso_n = tx_reg[7];
          tx_n   = {tx_reg[6:0], 1'b0};
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.miso     = miso_r;
  assign bus.data_out = dout;
  assign bus.done     = done_r;
  assign bus.abort    = abort_r;
  assign bus.buzy     = (state == ACTIVE);

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: single, chained, aborted, reset-interrupted
// and idle-toggled frames, plus 16 back-to-back random bytes.
module tb_spi_slave;

  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   done_cnt = 0;
  int   abort_cnt = 0;
  int   both_cnt = 0;
  logic [7:0] rx_q[$];

  spi_slave_if bus();

  spi_slave #(.SYNC_STAGES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Record done/abort pulses and the byte presented with each done
  always @(negedge clk) begin
    if (bus.done) begin
      done_cnt++;
      rx_q.push_back(bus.data_out);
    end
    if (bus.abort) abort_cnt++;
    if (bus.done && bus.abort) both_cnt++;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame_start(input logic [7:0] din);
    bus.data_in = din;
    bus.cs      = 1'b0;
    wait_clks(5);
  endtask

  task automatic frame_end();
    wait_clks(4);
    bus.cs = 1'b1;
    wait_clks(5);
  endtask

  // Master side: drive mosi in the low phase, sample miso at the rising edge.
  // data_in switches to next_din after the first rise so the byte-boundary
  // reload picks it up.
  task automatic shift_bits(input logic [7:0] mo, input int nbits, input int half,
                            input logic [7:0] next_din, output logic [7:0] mi);
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      bus.mosi = mo[7-i];
      wait_clks(half);
      mi[7-i]  = bus.miso;
      bus.sclk = 1'b1;
      if (i == 0) bus.data_in = next_din;
      wait_clks(half);
      bus.sclk = 1'b0;
    end
  endtask

  task automatic pop_rx(output logic [7:0] b);
    if (rx_q.size() > 0) b = rx_q.pop_front();
    else b = 8'hxx;
  endtask

  initial begin
    logic [7:0] mi, mi0, mi1, got;
    logic [7:0] txb[16];
    logic [7:0] rxb[16];
    logic [7:0] mib[16];
    logic       seen;
    int         d0, a0;

    reset = 1'b0;
    bus.cs = 1'b1; bus.sclk = 1'b0; bus.mosi = 1'b0; bus.data_in = 8'h00;
    wait_clks(2);
    chk("rst_miso", 16'(bus.miso), 16'h0);
    chk("rst_data_out", 16'(bus.data_out), 16'h00);
    chk("rst_done", 16'(bus.done), 16'h0);
    chk("rst_abort", 16'(bus.abort), 16'h0);
    chk("rst_buzy", 16'(bus.buzy), 16'h0);
    reset = 1'b1;
    wait_clks(6);

    // Single byte at clk/8
    d0 = done_cnt;
    frame_start(8'h3C);
    chk("t1_buzy", 16'(bus.buzy), 16'h1);
    shift_bits(8'hA5, 8, 4, 8'h3C, mi);
    frame_end();
    pop_rx(got);
    chk("t1_rx", 16'(got), 16'h00A5);
    chk("t1_miso", 16'(mi), 16'h003C);
    chk("t1_done_cnt", 16'(done_cnt - d0), 16'd1);
    chk("t1_buzy_end", 16'(bus.buzy), 16'h0);

    // Two bytes in one frame
    d0 = done_cnt;
    frame_start(8'h11);
    shift_bits(8'h01, 8, 4, 8'h22, mi0);
    shift_bits(8'hFE, 8, 4, 8'h22, mi1);
    frame_end();
    chk("t2_done_cnt", 16'(done_cnt - d0), 16'd2);
    pop_rx(got);
    chk("t2_rx0", 16'(got), 16'h0001);
    pop_rx(got);
    chk("t2_rx1", 16'(got), 16'h00FE);
    chk("t2_miso0", 16'(mi0), 16'h0011);
    chk("t2_miso1", 16'(mi1), 16'h0022);

    // Abort after 5 bits
    frame_start(8'h00);
    shift_bits(8'h5A, 8, 4, 8'h00, mi);
    frame_end();
    pop_rx(got);
    d0 = done_cnt; a0 = abort_cnt;
    frame_start(8'hAA);
    shift_bits(8'hFF, 5, 4, 8'hAA, mi);
    frame_end();
    chk("t3_abort_cnt", 16'(abort_cnt - a0), 16'd1);
    chk("t3_done_cnt", 16'(done_cnt - d0), 16'd0);
    chk("t3_data_out", 16'(bus.data_out), 16'h005A);
    frame_start(8'h00);
    shift_bits(8'hC3, 8, 4, 8'h00, mi);
    frame_end();
    pop_rx(got);
    chk("t3_rx_next", 16'(got), 16'h00C3);
    chk("t3_abort_total", 16'(abort_cnt - a0), 16'd1);

    // Reset mid-byte after 3 bits; cs still low at release
    d0 = done_cnt; a0 = abort_cnt;
    frame_start(8'h96);
    shift_bits(8'hFF, 3, 4, 8'h96, mi);
    wait_clks(4);
    chk("t4_pre_miso", 16'(bus.miso), 16'h1);
    chk("t4_pre_data_out", 16'(bus.data_out), 16'h00C3);
    reset = 1'b0;
    #1;
    chk("t4_data_out", 16'(bus.data_out), 16'h00);
    chk("t4_miso", 16'(bus.miso), 16'h0);
    chk("t4_buzy", 16'(bus.buzy), 16'h0);
    wait_clks(3);
    reset = 1'b1;
    wait_clks(10);
    chk("t4_idle_cs_low", 16'(bus.buzy), 16'h0);
    chk("t4_no_pulse", 16'((done_cnt - d0) + (abort_cnt - a0)), 16'd0);
    bus.cs = 1'b1;
    wait_clks(5);
    frame_start(8'h81);
    shift_bits(8'h7E, 8, 4, 8'h81, mi);
    frame_end();
    pop_rx(got);
    chk("t4_rx", 16'(got), 16'h007E);
    chk("t4_miso_byte", 16'(mi), 16'h0081);

    // sclk toggling with cs high
    d0 = done_cnt;
    seen = 1'b0;
    bus.data_in = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      bus.mosi = i[0];
      wait_clks(3);
      seen = seen | bus.miso | bus.buzy;
      bus.sclk = 1'b1;
      wait_clks(3);
      seen = seen | bus.miso | bus.buzy;
      bus.sclk = 1'b0;
    end
    wait_clks(4);
    chk("t5_miso_buzy", 16'(seen), 16'h0);
    chk("t5_done_cnt", 16'(done_cnt - d0), 16'd0);
    chk("t5_data_out", 16'(bus.data_out), 16'h007E);

    // 16 random back-to-back bytes at minimum phase
    for (int k = 0; k < 16; k++) begin
      txb[k] = 8'($urandom);
      rxb[k] = 8'($urandom);
    end
    d0 = done_cnt;
    frame_start(txb[0]);
    for (int k = 0; k < 16; k++) begin
      shift_bits(rxb[k], 8, 3, (k < 15) ? txb[k+1] : 8'h00, mi);
      mib[k] = mi;
    end
    frame_end();
    chk("t6_done_cnt", 16'(done_cnt - d0), 16'd16);
    for (int k = 0; k < 16; k++) begin
      pop_rx(got);
      chk($sformatf("t6_rx%0d", k), 16'(got), 16'(rxb[k]));
      chk($sformatf("t6_miso%0d", k), 16'(mib[k]), 16'(txb[k]));
    end
    chk("done_abort_overlap", 16'(both_cnt), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
